// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//
// Round-robin arbiter and sequencer for a 4-to-1 mux datapath. Picks one of
// four requesters, drives the mux select, registers the winner's data and
// holds it under a valid/ready handshake until the consumer takes it.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous, active-low reset
//   req[3:0]   in   request per requester (bit 0=a .. bit 3=d)
//   a,b,c,d    in   requester data, DW bits each
//   gnt[3:0]   out  one-hot grant, one-cycle pulse in the cycle after capture
//   sel[1:0]   out  select of the current / last winner (0=a .. 3=d)
//   out_valid  out  out_data holds an untransferred word
//   out_data   out  registered mux output, DW bits
//   out_ready  in   consumer accepts the word at an edge when out_valid=1
// ---------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [DW-1:0] data_q, data_d;

    logic [3:0]    elig;
    logic [1:0]    win;
    logic          win_found;
    logic [DW-1:0] win_data;
    logic          capture;

    // The requester granted last cycle is masked so its already-consumed
    // word cannot be captured a second time.
    assign elig = req & ~gnt_q;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first eligible index wins.
    // NOTE: every variable written in a combinational block gets a default
    // first, otherwise paths that skip the assignment infer a latch.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!win_found && elig[ptr_q + 2'(k)]) begin
                win       = ptr_q + 2'(k);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = a;
        case (win)
            2'd0: win_data = a;
            2'd1: win_data = b;
            2'd2: win_data = c;
            2'd3: win_data = d;
            default: win_data = a;
        endcase
    end

    // A new word may be taken whenever the output register is empty or is
    // being emptied at this edge.
    assign capture = win_found && ((state_q == IDLE) || out_ready);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        gnt_d   = 4'b0000;
        if (capture) begin
            state_d = BUSY;
            sel_d   = win;
            data_d  = win_data;
            gnt_d   = 4'b0001 << win;
            ptr_d   = win + 2'd1;
        end else if (state_q == BUSY && out_ready) begin
            // Transfer with nothing to replace it: sel and data keep their values.
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = (state_q == BUSY);
    assign out_data  = data_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [DW-1:0] din [4];
    logic          out_ready = 1'b0;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: the word sitting at the output and who sent it.
    bit         m_valid;
    logic [3:0] m_data;
    int         m_sel;
    int         m_ptr;
    int         m_last;   // index granted at the previous edge, -1 if none

    mux_rr_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a         (din[0]),
        .b         (din[1]),
        .c         (din[2]),
        .d         (din[3]),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_data  = 4'h0;
        m_sel   = 0;
        m_ptr   = 0;
        m_last  = -1;
    endtask

    // One edge of the spec's behaviour, evaluated on the pre-edge inputs.
    task automatic model_edge();
        int w;
        w = -1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_valid || out_ready) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (w < 0 && req[i] && i != m_last) w = i;
            end
            if (w >= 0) begin
                m_valid = 1;
                m_sel   = w;
                m_data  = din[w];
                m_ptr   = (w + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        m_last = w;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        eg = (m_last >= 0) ? (4'b0001 << m_last) : 4'b0000;
        check({tag, ".valid"}, {3'b000, out_valid}, {3'b000, m_valid});
        check({tag, ".data"},  out_data, m_data);
        check({tag, ".sel"},   {2'b00, sel}, 4'(m_sel));
        check({tag, ".gnt"},   gnt, eg);
    endtask

    // Advance one edge, sample #1 later, compare against the model.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("reset_async");
        tick("reset_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) din[i] = 4'h0;
        model_reset();

        // Power-on reset.
        @(posedge clk);
        #1;
        check_model("por");
        rst_n = 1'b1;

        // Single request: word 5 from a, then a repeat capture two cycles later.
        din[0] = 4'h5; req = 4'b0001; out_ready = 1'b1;
        tick("single1");
        check("single.data", out_data, 4'h5);
        check("single.gnt", gnt, 4'b0001);
        tick("single2");
        check("single.masked_valid", {3'b000, out_valid}, 4'h0);
        tick("single3");
        check("single.again_gnt", gnt, 4'b0001);
        req = 4'b0000;
        tick("single_drain");

        // Reset mid-BUSY with backpressure, then a is granted from ptr=0.
        req = 4'b0010; din[1] = 4'h9; out_ready = 1'b0;
        tick("rst_busy_fill");
        tick("rst_busy_hold");
        do_reset();
        check("rst_busy.valid", {3'b000, out_valid}, 4'h0);
        req = 4'b0001; din[0] = 4'h3;
        tick("rst_after");
        check("rst_after.gnt", gnt, 4'b0001);

        // Full contention from ptr=0: 0,2,4,8,0 on consecutive cycles.
        do_reset();
        din[0] = 4'h0; din[1] = 4'h2; din[2] = 4'h4; din[3] = 4'h8;
        req = 4'b1111; out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            logic [3:0] exp_d;
            exp_d = (n % 4 == 0) ? 4'h0 : (4'h1 << (n % 4));
            tick("contend");
            check("contend.data", out_data, exp_d);
            check("contend.valid", {3'b000, out_valid}, 4'h1);
        end

        // Backpressure: c holds word 4 for 3 cycles while req toggles.
        do_reset();
        req = 4'b0100; din[2] = 4'h4; out_ready = 1'b0;
        tick("bp_fill");
        for (int n = 0; n < 3; n++) begin
            req = (n % 2 == 0) ? 4'b1001 : 4'b0110;
            tick("bp_hold");
            check("bp.data", out_data, 4'h4);
            check("bp.sel", {2'b00, sel}, 4'h2);
            check("bp.gnt", gnt, 4'b0000);
        end
        req = 4'b1111; din[3] = 4'hd; out_ready = 1'b1;
        tick("bp_release");
        check("bp.next_is_d", gnt, 4'b1000);

        // Wrap-around: after d (ptr=0) req=1001 grants a before d.
        req = 4'b1001; din[0] = 4'ha;
        tick("wrap1_a");
        check("wrap1.first", gnt, 4'b0001);
        tick("wrap1_d");
        check("wrap1.second", gnt, 4'b1000);

        // After c (ptr=3) req=1001 grants d first, then a.
        do_reset();
        req = 4'b0100;
        tick("wrap2_c");
        req = 4'b1001;
        tick("wrap2_d");
        check("wrap2.first", gnt, 4'b1000);
        tick("wrap2_a");
        check("wrap2.second", gnt, 4'b0001);

        // Drain to IDLE: data and sel retained.
        req = 4'b0000;
        tick("drain");
        check("drain.valid", {3'b000, out_valid}, 4'h0);
        check("drain.data", out_data, 4'ha);
        check("drain.sel", {2'b00, sel}, 4'h0);

        // Randomized traffic against the model, with an occasional reset.
        for (int n = 0; n < 400; n++) begin
            req       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) din[i] = 4'($urandom);
            if (n == 200) do_reset();
            else tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
